// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Package : elevator_pkg
// Brief   : Shared constants and types for the elevator call scheduler:
//           default floor count and index width, button-vector width,
//           travel-direction codes, FSM state encoding and the
//           floor-search modes used by elevator_floor_search.
// Revision: 1.0 - initial release
// ============================================================================
package elevator_pkg;

  localparam int NUM_FLOORS = 16;
  localparam int FLOOR_W    = 4;
  localparam int BTN_W      = 16;

  localparam logic [1:0] DIR_IDLE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DOWN = 2'd2;

  // State codes equal the direction codes so the direction outputs are a
  // plain decode of the state register.
  typedef enum logic [1:0] {
    ST_IDLE       = DIR_IDLE,
    ST_SERVE_UP   = DIR_UP,
    ST_SERVE_DOWN = DIR_DOWN
  } state_e;

  typedef enum logic [1:0] {
    SRCH_LOWEST_ABOVE  = 2'd0,
    SRCH_HIGHEST_ABOVE = 2'd1,
    SRCH_HIGHEST_BELOW = 2'd2,
    SRCH_LOWEST_BELOW  = 2'd3
  } search_mode_e;

endpackage
`default_nettype wire

// File: rtl/elevator_floor_search.sv
`default_nettype none
// ============================================================================
// Module  : elevator_floor_search
// Brief   : Combinational priority search over a floor mask relative to a
//           reference floor. Returns the lowest/highest set bit strictly
//           above or strictly below ref_floor.
// Ports   : mask      in  BTN_W    candidate floors
//           ref_floor in  FLOOR_W  reference floor (excluded from search)
//           mode      in  2        search mode (search_mode_e)
//           found     out 1        a candidate exists
//           idx       out FLOOR_W  index of the candidate (0 when none)
// Revision: 1.0 - initial release
// ============================================================================
module elevator_floor_search #(
  parameter int FLOOR_W = elevator_pkg::FLOOR_W,
  parameter int BTN_W   = elevator_pkg::BTN_W
) (
  input  logic [BTN_W-1:0]            mask,
  input  logic [FLOOR_W-1:0]          ref_floor,
  input  elevator_pkg::search_mode_e  mode,
  output logic                        found,
  output logic [FLOOR_W-1:0]          idx
);
  import elevator_pkg::*;

  logic want_above;
  logic want_highest;

  assign want_above   = (mode == SRCH_LOWEST_ABOVE)  || (mode == SRCH_HIGHEST_ABOVE);
  assign want_highest = (mode == SRCH_HIGHEST_ABOVE) || (mode == SRCH_HIGHEST_BELOW);

  // Ascending scan: "lowest" keeps the first hit, "highest" keeps the last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < BTN_W; i++) begin
      if (mask[i] &&
          (want_above ? (i > int'(ref_floor)) : (i < int'(ref_floor))) &&
          (want_highest || !found)) begin
        found = 1'b1;
        idx   = FLOOR_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/elevator_call_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : elevator_call_scheduler
// Brief   : Latches cab and hall calls, picks the car's next destination in
//           SCAN (collective) order, clears calls as the door opens at a
//           floor, and parks an idle car at HOME_FLOOR after HOME_TIMEOUT
//           idle cycles.
// Ports   : clk, reset_n (async, active-low)
//           cab_buttons / hall_up / hall_down  in  16  call presses
//           current_floor in 4, car_moving in 1, door_open in 1
//           target_floor out 4, target_valid out 1 (registered)
//           dir_up / dir_down out 1 (state decode, mutually exclusive)
//           cab_lamps / hall_up_lamps / hall_down_lamps out 16 (pending calls)
// Revision: 1.0 - initial release
// ============================================================================
module elevator_call_scheduler #(
  parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
  parameter int HOME_FLOOR   = 0,
  parameter int HOME_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        cab_buttons,
  input  logic [15:0]        hall_up,
  input  logic [15:0]        hall_down,
  input  logic [FLOOR_W-1:0] current_floor,
  input  logic               car_moving,
  input  logic               door_open,
  output logic [FLOOR_W-1:0] target_floor,
  output logic               target_valid,
  output logic               dir_up,
  output logic               dir_down,
  output logic [15:0]        cab_lamps,
  output logic [15:0]        hall_up_lamps,
  output logic [15:0]        hall_down_lamps
);
  import elevator_pkg::*;

  localparam int CNT_W = (HOME_TIMEOUT < 2) ? 1 : $clog2(HOME_TIMEOUT + 1);

  // Registers
  logic [BTN_W-1:0]   cab_q, cab_d;
  logic [BTN_W-1:0]   hup_q, hup_d;
  logic [BTN_W-1:0]   hdn_q, hdn_d;
  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] target_floor_q, target_floor_d;
  logic               target_valid_q, target_valid_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;

  // Combinational helpers
  logic [BTN_W-1:0]   floor_mask, hup_mask, hdn_mask;
  logic [BTN_W-1:0]   all_calls, cur_onehot, home_set;
  logic [BTN_W-1:0]   mask_a, mask_c;
  logic               in_idle, idle_cond, at_cur;
  logic               a_found, b_found, c_found, d_found;
  logic [FLOOR_W-1:0] a_idx, b_idx, c_idx, d_idx;
  logic [FLOOR_W:0]   dist_up, dist_dn;

  // Valid button bits: floors beyond the top are ignored, the top floor has
  // no up call and the bottom floor has no down call.
  for (genvar g = 0; g < BTN_W; g++) begin : g_btn_mask
    assign floor_mask[g] = (g < NUM_FLOORS) ? 1'b1 : 1'b0;
    assign hup_mask[g]   = (g < NUM_FLOORS - 1) ? 1'b1 : 1'b0;
    assign hdn_mask[g]   = ((g > 0) && (g < NUM_FLOORS)) ? 1'b1 : 1'b0;
  end

  assign all_calls  = cab_q | hup_q | hdn_q;
  assign cur_onehot = BTN_W'(1) << current_floor;
  assign in_idle    = (state_q == ST_IDLE);
  assign at_cur     = |(all_calls & cur_onehot);
  assign idle_cond  = in_idle && !(|all_calls) && !door_open && !car_moving;

  // In IDLE the lowest-above / highest-below searches look at every call so
  // they yield the nearest call in each direction; while serving they look
  // only at calls that fit the SCAN sweep.
  assign mask_a = in_idle ? all_calls : (cab_q | hup_q);
  assign mask_c = in_idle ? all_calls : (cab_q | hdn_q);

  elevator_floor_search #(.FLOOR_W(FLOOR_W), .BTN_W(BTN_W)) u_srch_lowest_above (
    .mask(mask_a), .ref_floor(current_floor), .mode(SRCH_LOWEST_ABOVE),
    .found(a_found), .idx(a_idx)
  );
  elevator_floor_search #(.FLOOR_W(FLOOR_W), .BTN_W(BTN_W)) u_srch_highest_above (
    .mask(hdn_q), .ref_floor(current_floor), .mode(SRCH_HIGHEST_ABOVE),
    .found(b_found), .idx(b_idx)
  );
  elevator_floor_search #(.FLOOR_W(FLOOR_W), .BTN_W(BTN_W)) u_srch_highest_below (
    .mask(mask_c), .ref_floor(current_floor), .mode(SRCH_HIGHEST_BELOW),
    .found(c_found), .idx(c_idx)
  );
  elevator_floor_search #(.FLOOR_W(FLOOR_W), .BTN_W(BTN_W)) u_srch_lowest_below (
    .mask(hup_q), .ref_floor(current_floor), .mode(SRCH_LOWEST_BELOW),
    .found(d_found), .idx(d_idx)
  );

  assign dist_up = {1'b0, a_idx} - {1'b0, current_floor};
  assign dist_dn = {1'b0, current_floor} - {1'b0, c_idx};

  // Idle counter and home-call injection
  always_comb begin
    home_set   = '0;
    idle_cnt_d = idle_cnt_q;
    if ((HOME_TIMEOUT == 0) || !idle_cond) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == CNT_W'(HOME_TIMEOUT - 1)) begin
      idle_cnt_d = '0;
      if (current_floor != FLOOR_W'(HOME_FLOOR)) begin
        home_set[HOME_FLOOR] = 1'b1;
      end
    end else begin
      idle_cnt_d = idle_cnt_q + CNT_W'(1);
    end
  end

  // Call registers. Clearing on the door_open level covers the rising edge
  // and also blocks re-latching at this floor while the door stays open.
  always_comb begin
    cab_d = (cab_q | (cab_buttons & floor_mask) | home_set)
            & ~(door_open ? cur_onehot : '0);
    hup_d = (hup_q | (hall_up & hup_mask))
            & ~((door_open && (state_q != ST_SERVE_DOWN)) ? cur_onehot : '0);
    hdn_d = (hdn_q | (hall_down & hdn_mask))
            & ~((door_open && (state_q != ST_SERVE_UP)) ? cur_onehot : '0);
  end

  // Next-state / target selection
  always_comb begin
    state_d        = state_q;
    target_floor_d = target_floor_q;
    target_valid_d = target_valid_q;
    case (state_q)
      ST_IDLE: begin
        target_valid_d = 1'b0;
        if (at_cur) begin
          target_floor_d = current_floor;
          target_valid_d = 1'b1;
        end else if (a_found && (!c_found || (dist_up <= dist_dn))) begin
          state_d        = ST_SERVE_UP;
          target_floor_d = a_idx;
          target_valid_d = 1'b1;
        end else if (c_found) begin
          state_d        = ST_SERVE_DOWN;
          target_floor_d = c_idx;
          target_valid_d = 1'b1;
        end
      end
      ST_SERVE_UP: begin
        target_valid_d = 1'b1;
        if (a_found) begin
          target_floor_d = a_idx;
        end else if (b_found) begin
          target_floor_d = b_idx;
        end else if (!car_moving) begin
          if (c_found || d_found) begin
            state_d        = ST_SERVE_DOWN;
            target_floor_d = c_found ? c_idx : d_idx;
          end else begin
            state_d        = ST_IDLE;
            target_valid_d = 1'b0;
          end
        end
      end
      ST_SERVE_DOWN: begin
        target_valid_d = 1'b1;
        if (c_found) begin
          target_floor_d = c_idx;
        end else if (d_found) begin
          target_floor_d = d_idx;
        end else if (!car_moving) begin
          if (a_found || b_found) begin
            state_d        = ST_SERVE_UP;
            target_floor_d = a_found ? a_idx : b_idx;
          end else begin
            state_d        = ST_IDLE;
            target_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d        = ST_IDLE;
        target_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cab_q          <= '0;
      hup_q          <= '0;
      hdn_q          <= '0;
      state_q        <= ST_IDLE;
      target_floor_q <= '0;
      target_valid_q <= 1'b0;
      idle_cnt_q     <= '0;
    end else begin
      cab_q          <= cab_d;
      hup_q          <= hup_d;
      hdn_q          <= hdn_d;
      state_q        <= state_d;
      target_floor_q <= target_floor_d;
      target_valid_q <= target_valid_d;
      idle_cnt_q     <= idle_cnt_d;
    end
  end

  assign target_floor    = target_floor_q;
  assign target_valid    = target_valid_q;
  assign dir_up          = (state_q == ST_SERVE_UP);
  assign dir_down        = (state_q == ST_SERVE_DOWN);
  assign cab_lamps       = cab_q;
  assign hall_up_lamps   = hup_q;
  assign hall_down_lamps = hdn_q;

endmodule
`default_nettype wire
